// File: rtl/nn_pkg.sv
// Purpose: shared widths, FSM encoding and saturation helper for the output-layer neurons.
// Latency: n/a (package, no logic).
// Backpressure: n/a.
package nn_pkg;

    localparam int N_HID  = 300;
    localparam int ADDR_W = 9;
    localparam int W_W    = 21;
    localparam int ACT_W  = 16;
    localparam int OUT_W  = 21;
    localparam int PROD_W = W_W + ACT_W;
    // Headroom of ADDR_W bits: 2^9 products of full-scale magnitude can never overflow.
    localparam int ACC_W  = W_W + ACT_W + ADDR_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } fsm_t;

    // Clamp a signed value to the range representable in 'width' bits.
    // The result is returned at 64 bits; callers take the low 'width' bits.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            sat_signed = max_v;
        end else if (value < min_v) begin
            sat_signed = min_v;
        end else begin
            sat_signed = value;
        end
    endfunction

endpackage

// File: rtl/out_neuron_mac.sv
// Purpose: sequential MAC for one output neuron; walks ROM/activation addresses 0..N_IN-1,
//          accumulates w*act, then emits sat((acc >>> FRAC_SHIFT) + bias).
// Latency: out_valid rises N_IN+1 edges after start is accepted, plus one edge per act_vld=0 cycle.
// Backpressure: act_vld=0 stalls the address walk; result is held in DONE until out_ready=1.
//
// Ports: clk/rst_n (async active-low); start + bias (sampled on accept);
//        adrs_clm -> ROM and activation buffer, w_in/act_in/act_vld returned same cycle;
//        busy = not IDLE; out_valid/out_ready/out_data result handshake.
module out_neuron_mac
    import nn_pkg::*;
#(
    parameter int N_IN       = N_HID,
    parameter int FRAC_SHIFT = 0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic signed [OUT_W-1:0]  bias,
    output logic        [ADDR_W-1:0] adrs_clm,
    input  logic signed [W_W-1:0]    w_in,
    input  logic signed [ACT_W-1:0]  act_in,
    input  logic                     act_vld,
    output logic                     busy,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data
);

    localparam logic [ADDR_W-1:0] LAST_ADR = ADDR_W'(N_IN - 1);

    fsm_t                     state_q;
    logic        [ADDR_W-1:0] adrs_q;
    logic signed [PROD_W-1:0] prod_q;
    logic signed [PROD_W-1:0] prod_d;
    logic                     pv_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_fin_d;
    logic signed [OUT_W-1:0]  bias_q;
    logic signed [OUT_W-1:0]  out_data_q;
    logic signed [OUT_W-1:0]  out_data_d;
    logic                     out_valid_q;

    always_comb begin
        prod_d     = PROD_W'(w_in) * PROD_W'(act_in);
        // In DRAIN the last product is still in prod_q, so fold it in before scaling.
        acc_fin_d  = acc_q + (pv_q ? ACC_W'(prod_q) : ACC_W'(0));
        out_data_d = OUT_W'(sat_signed(64'(acc_fin_d >>> FRAC_SHIFT) + 64'(bias_q), OUT_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            adrs_q      <= '0;
            prod_q      <= '0;
            pv_q        <= 1'b0;
            acc_q       <= '0;
            bias_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            // Accumulate stage runs independently of the FSM; IDLE clear below overrides it.
            if (pv_q) begin
                acc_q <= acc_q + ACC_W'(prod_q);
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        acc_q   <= '0;
                        bias_q  <= bias;
                        adrs_q  <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (act_vld) begin
                        prod_q <= prod_d;
                        pv_q   <= 1'b1;
                        if (adrs_q == LAST_ADR) begin
                            state_q <= DRAIN;
                        end else begin
                            adrs_q <= adrs_q + 1'b1;
                        end
                    end else begin
                        pv_q <= 1'b0;
                    end
                end
                DRAIN: begin
                    pv_q        <= 1'b0;
                    out_data_q  <= out_data_d;
                    out_valid_q <= 1'b1;
                    state_q     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign adrs_clm  = adrs_q;
    assign busy      = (state_q != IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule
